// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core: next-PC selector codes, reset PC and
// instruction-memory geometry.
package cpu_pkg;

    // Next-PC selector codes driven by the decode-stage controller.
    localparam logic [2:0] NPC_SEQ = 3'b000;  // pc_f + 4
    localparam logic [2:0] NPC_BR  = 3'b001;  // conditional branch
    localparam logic [2:0] NPC_J   = 3'b010;  // j / jal
    localparam logic [2:0] NPC_JR  = 3'b011;  // jr / jalr

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;

    // Instruction word loaded into IF/ID on reset.
    localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selector. Branch and jump targets are formed from the
// decode-stage PC (pc_d) because the control instruction sits in ID while the
// delay slot is being fetched at pc_f.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [2:0]  npc_op,
    input  logic        cmp,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_fwd,
    output logic [31:0] npc
);

    logic [31:0] seq_target;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign seq_target = pc_f + 32'd4;
    assign br_target  = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_target   = {pc_d[31:28], instr_index, 2'b00};

    // Select the next fetch address; unknown selector codes fall back to sequential.
    always_comb begin
        npc = seq_target;
        case (npc_op)
            NPC_BR:  npc = cmp ? br_target : seq_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = rs_fwd;
            default: npc = seq_target;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter and IF/ID pipeline register with delayed-branch
// semantics: the slot instruction at pc_f is always latched, never squashed.
// A sticky fault flag records any load of a misaligned or out-of-range PC.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET_VAL = PC_RESET,
    parameter logic [31:0] IM_BASE_VAL  = IM_BASE,
    parameter int          IM_DEPTH     = IM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        cmp,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_fwd,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] ir_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        fault
);

    // Highest word-aligned legal fetch address.
    localparam logic [31:0] IM_LAST = IM_BASE_VAL + 32'(IM_DEPTH) * 32'd4 - 32'd4;

    logic [31:0] npc;
    logic        npc_legal;

    npc_calc u_npc_calc (
        .npc_op      (npc_op),
        .cmp         (cmp),
        .pc_f        (pc_f),
        .pc_d        (pc_d),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_fwd      (rs_fwd),
        .npc         (npc)
    );

    // Legal target: word aligned and inside instruction memory.
    always_comb begin
        npc_legal = (npc[1:0] == 2'b00) && (npc >= IM_BASE_VAL) && (npc <= IM_LAST);
    end

    assign pc8_d = pc_d + 32'd8;

    // PC and IF/ID registers advance together; a stall freezes both so the
    // branch in ID is re-evaluated on the first unstalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f  <= PC_RESET_VAL;
            ir_d  <= NOP_WORD;
            pc_d  <= PC_RESET_VAL;
            fault <= 1'b0;
        end else if (!stall) begin
            pc_f <= npc;
            ir_d <= instr_f;
            pc_d <= pc_f;
            if (!npc_legal) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage program counter and IF/ID pipeline register for the 5-stage MIPS core.
- Consumes the decode-stage branch-compare result and the decoded next-PC selector, and produces the fetch address.
- Latches fetched instructions into the decode stage.
- Delayed-branch semantics: the instruction after a branch or jump always executes.

Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_WORDS, 4096, instruction-memory depth in words; legal range is IM_BASE .. IM_BASE+4*IM_WORDS-4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit stall; freezes PC and IF/ID
- npc_op  in  3  decode-stage selector: 000 seq, 001 cond branch, 010 j/jal, 011 jr/jalr; others treated as seq
- cmp  in  1  branch-taken flag from the decode-stage comparator
- imm16  in  16  branch offset from ir_d
- instr_index  in  26  jump index from ir_d
- rs_fwd  in  32  forwarded rs value for jr/jalr
- instr_f  in  32  instruction word read at pc_f
- pc_f  out  32  current fetch address
- ir_d  out  32  IF/ID instruction register
- pc_d  out  32  IF/ID PC register
- pc8_d  out  32  pc_d+8, the link value
- fault  out  1  sticky illegal-fetch-target flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_f=PC_RESET, ir_d=32'h0 (nop), pc_d=PC_RESET, fault=0.
  - Deassertion is sampled at the next rising edge; no next-PC is loaded while rst_n=0.
- Next-PC computation (combinational, 32-bit wrap-around arithmetic):
  - seq: pc_f+4.
  - branch: if cmp=1, pc_d+4+(sign_extend(imm16)<<2); if cmp=0, pc_f+4.
  - j/jal: {pc_d[31:28], instr_index, 2'b00}.
  - jr/jalr: rs_fwd, taken unmodified.
- Clock edge with stall=0:
  - pc_f<=npc.
  - ir_d<=instr_f.
  - pc_d<=pc_f.
- Clock edge with stall=1:
  - pc_f, ir_d and pc_d hold.
  - npc_op and cmp are ignored, because the branch in decode stays in decode and is re-evaluated on the first unstalled cycle.
- Delay slot:
  - When the branch is in ID, the instruction at pc_f (branch PC+4) is the slot.
  - The slot is latched normally and is never squashed.
  - Redirect latency: one cycle from the branch entering ID to pc_f = target.
- pc8_d = pc_d+8, combinational, wraps mod 2^32.
- Fault detection:
  - An illegal target is any npc with npc[1:0]!=0, npc<IM_BASE, or npc beyond the legal range, loaded on an unstalled edge.
  - On such a load, fault<=1 at that edge. fault stays set until reset.
  - pc_f still loads the illegal value. Fetch behaviour past that point is undefined; the testbench only checks fault.
- Simultaneous events:
  - stall=1 with any npc_op: hold has priority.
  - rst_n low mid-stall or mid-branch: reset has priority, and the pending branch is lost.
- Timing contract: cmp and rs_fwd are valid before the edge in the same cycle the branch sits in ID. There is no internal buffering of them.

Decomposition:
- Shared package cpu_pkg:
  - NPC_SEQ, NPC_BR, NPC_J, NPC_JR 3-bit constants, also used by the controller.
  - PC_RESET default.
  - NOP_WORD = 32'h0.
- Sub-module npc_calc: purely combinational. Inputs: npc_op, cmp, pc_f, pc_d, imm16, instr_index, rs_fwd. Output: npc.
- fetch_pc_unit holds the registers and the fault logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release.
  - Expected: pc_f=0x3000, ir_d=0, pc_d=0x3000.
  - After 3 unstalled cycles: pc_f=0x300C, pc_d=0x3008.
- Taken branch with negative offset: pc_d=0x3010, npc_op=001, cmp=1, imm16=16'hFFFC.
  - Expected next pc_f=0x3004.
  - The prior pc_f=0x3014 slot still appears in ir_d/pc_d.
- Not-taken branch: same setup, cmp=0.
  - Expected next pc_f=0x3018.
  - pc8_d=0x3018 while pc_d=0x3010.
- Stall with branch: stall=1 for 3 cycles while npc_op=001, cmp=1.
  - Expected: pc_f, ir_d, pc_d frozen.
  - First edge with stall=0 redirects to the target.
- jr misaligned: npc_op=011, rs_fwd=0x3002.
  - Expected: pc_f=0x3002 and fault=1 after the edge.
  - fault stays 1 through subsequent legal jumps until rst_n=0.
- jal: pc_d=0x3020, instr_index=26'h0000C10.
  - Expected pc_f=0x0000_3040.
  - Async reset asserted mid-cycle immediately forces pc_f=0x3000.
